// File: rtl/reg_scoreboard.sv
// reg_scoreboard: pending-write scoreboard sitting beside decode.
// Holds one small counter per scalar register, per vector register and
// for the condition code. It stalls issue on RAW hazards (a source has
// writes in flight) and on counter saturation (a destination already has
// MAX_INFLIGHT writes outstanding). Writeback retire events decrement the
// counters.
//
// Ports:
//   I_CLOCK, I_RESET_N          clock (rising edge), async active-low reset
//   I_IssueValid, I_Hold        decode has an instruction / downstream stall
//   I_Src*/I_Dest*              scalar operand and destination indices + enables
//   I_VSrc*/I_VDest*            vector operand and destination indices + enables
//   I_CCRead, I_CCWrite         condition-code read / write
//   I_WB*                       writeback retire events (scalar, vector, CC)
//   O_DepStall, O_Issue         combinational hazard / issue decision
//   O_Busy                      registered: any counter non-zero
//   O_Underflow                 registered, sticky: retire against an empty counter
module reg_scoreboard #(
    parameter int NUM_RF       = 16,
    parameter int NUM_VRF      = 64,
    parameter int VREG_ID_W    = 6,
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic                       I_CLOCK,
    input  logic                       I_RESET_N,
    input  logic                       I_IssueValid,
    input  logic                       I_Hold,
    input  logic [$clog2(NUM_RF)-1:0]  I_Src1Idx,
    input  logic                       I_Src1Use,
    input  logic [$clog2(NUM_RF)-1:0]  I_Src2Idx,
    input  logic                       I_Src2Use,
    input  logic [$clog2(NUM_RF)-1:0]  I_DestIdx,
    input  logic                       I_DestWrite,
    input  logic [VREG_ID_W-1:0]       I_VSrc1Idx,
    input  logic                       I_VSrc1Use,
    input  logic [VREG_ID_W-1:0]       I_VSrc2Idx,
    input  logic                       I_VSrc2Use,
    input  logic [VREG_ID_W-1:0]       I_VDestIdx,
    input  logic                       I_VDestWrite,
    input  logic                       I_CCRead,
    input  logic                       I_CCWrite,
    input  logic                       I_WBRegEn,
    input  logic [$clog2(NUM_RF)-1:0]  I_WBRegIdx,
    input  logic                       I_WBVRegEn,
    input  logic [VREG_ID_W-1:0]       I_WBVRegIdx,
    input  logic                       I_WBCCEn,
    output logic                       O_DepStall,
    output logic                       O_Issue,
    output logic                       O_Busy,
    output logic                       O_Underflow
);

    localparam int RF_ID_W = $clog2(NUM_RF);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_RF-1:0][CNT_W-1:0]  r_rf_cnt,  w_rf_nxt;
    logic [NUM_VRF-1:0][CNT_W-1:0] r_vrf_cnt, w_vrf_nxt;
    logic [CNT_W-1:0]              r_cc_cnt,  w_cc_nxt;
    logic                          r_busy, r_underflow;
    logic                          w_raw, w_sat, w_uf;

    // Hazards look only at current counters: a retire in this cycle does
    // not release a dependent instruction until the following cycle.
    assign w_raw = (I_Src1Use  && r_rf_cnt[I_Src1Idx]   != '0) ||
                   (I_Src2Use  && r_rf_cnt[I_Src2Idx]   != '0) ||
                   (I_VSrc1Use && r_vrf_cnt[I_VSrc1Idx] != '0) ||
                   (I_VSrc2Use && r_vrf_cnt[I_VSrc2Idx] != '0) ||
                   (I_CCRead   && r_cc_cnt              != '0);

    assign w_sat = (I_DestWrite  && r_rf_cnt[I_DestIdx]   == CNT_MAX) ||
                   (I_VDestWrite && r_vrf_cnt[I_VDestIdx] == CNT_MAX) ||
                   (I_CCWrite    && r_cc_cnt              == CNT_MAX);

    assign O_DepStall = I_IssueValid && (w_raw || w_sat);
    assign O_Issue    = I_IssueValid && !O_DepStall && !I_Hold;

    // A retire against an empty counter is a protocol error; flag it.
    assign w_uf = (I_WBRegEn  && r_rf_cnt[I_WBRegIdx]   == '0) ||
                  (I_WBVRegEn && r_vrf_cnt[I_WBVRegIdx] == '0) ||
                  (I_WBCCEn   && r_cc_cnt               == '0);

    // Issue increments and retire decrements cancel in the same cycle.
    // The decrement is suppressed at zero so counters never wrap.
    always_comb begin
        w_rf_nxt = r_rf_cnt;
        for (int i = 0; i < NUM_RF; i++) begin
            if ((O_Issue && I_DestWrite && I_DestIdx == RF_ID_W'(i)) &&
                !(I_WBRegEn && I_WBRegIdx == RF_ID_W'(i) && r_rf_cnt[i] != '0))
                w_rf_nxt[i] = r_rf_cnt[i] + CNT_ONE;
            else if (!(O_Issue && I_DestWrite && I_DestIdx == RF_ID_W'(i)) &&
                     (I_WBRegEn && I_WBRegIdx == RF_ID_W'(i) && r_rf_cnt[i] != '0))
                w_rf_nxt[i] = r_rf_cnt[i] - CNT_ONE;
        end
    end

    always_comb begin
        w_vrf_nxt = r_vrf_cnt;
        for (int i = 0; i < NUM_VRF; i++) begin
            if ((O_Issue && I_VDestWrite && I_VDestIdx == VREG_ID_W'(i)) &&
                !(I_WBVRegEn && I_WBVRegIdx == VREG_ID_W'(i) && r_vrf_cnt[i] != '0))
                w_vrf_nxt[i] = r_vrf_cnt[i] + CNT_ONE;
            else if (!(O_Issue && I_VDestWrite && I_VDestIdx == VREG_ID_W'(i)) &&
                     (I_WBVRegEn && I_WBVRegIdx == VREG_ID_W'(i) && r_vrf_cnt[i] != '0))
                w_vrf_nxt[i] = r_vrf_cnt[i] - CNT_ONE;
        end
    end

    always_comb begin
        w_cc_nxt = r_cc_cnt;
        if ((O_Issue && I_CCWrite) && !(I_WBCCEn && r_cc_cnt != '0))
            w_cc_nxt = r_cc_cnt + CNT_ONE;
        else if (!(O_Issue && I_CCWrite) && (I_WBCCEn && r_cc_cnt != '0))
            w_cc_nxt = r_cc_cnt - CNT_ONE;
    end

    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_rf_cnt    <= '0;
            r_vrf_cnt   <= '0;
            r_cc_cnt    <= '0;
            r_busy      <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_rf_cnt    <= w_rf_nxt;
            r_vrf_cnt   <= w_vrf_nxt;
            r_cc_cnt    <= w_cc_nxt;
            // Busy follows next-state so it reflects this edge's updates.
            r_busy      <= (|w_rf_nxt) || (|w_vrf_nxt) || (|w_cc_nxt);
            r_underflow <= r_underflow || w_uf;
        end
    end

    assign O_Busy      = r_busy;
    assign O_Underflow = r_underflow;

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Pending-write scoreboard that decides when decode may issue an instruction.
- Tracks outstanding writes to the scalar RF, the vector RF and the condition code.
- Raises a dependency stall on RAW hazards and on counter saturation; clears pending state on writeback.
- Sits beside decode: decode supplies operand/destination indices; writeback supplies retire events. Replaces per-stage ED/MD destination comparisons with a single in-flight tracker.

Parameters:
- NUM_RF, 16, number of scalar registers (scalar index width 4)
- NUM_VRF, 64, number of vector registers
- VREG_ID_W, 6, vector register index width
- CNT_W, 2, width of each per-register pending counter
- MAX_INFLIGHT, 3, maximum outstanding writes per register/CC (must be ≤ 2^CNT_W−1)

Ports:
- I_CLOCK  in  1  clock, rising edge
- I_RESET_N  in  1  asynchronous active-low reset
- I_IssueValid  in  1  decode holds a valid instruction
- I_Hold  in  1  downstream/GPU stall; blocks issue
- I_Src1Idx  in  4  scalar source 1 index
- I_Src1Use  in  1  source 1 is read
- I_Src2Idx  in  4  scalar source 2 index
- I_Src2Use  in  1  source 2 is read
- I_DestIdx  in  4  scalar destination index
- I_DestWrite  in  1  instruction writes the scalar destination
- I_VSrc1Idx  in  VREG_ID_W  vector source 1 index
- I_VSrc1Use  in  1  vector source 1 is read
- I_VSrc2Idx  in  VREG_ID_W  vector source 2 index
- I_VSrc2Use  in  1  vector source 2 is read
- I_VDestIdx  in  VREG_ID_W  vector destination index
- I_VDestWrite  in  1  instruction writes the vector destination
- I_CCRead  in  1  instruction reads CC (branches)
- I_CCWrite  in  1  instruction writes CC
- I_WBRegEn  in  1  scalar writeback this cycle
- I_WBRegIdx  in  4  scalar writeback index
- I_WBVRegEn  in  1  vector writeback this cycle
- I_WBVRegIdx  in  VREG_ID_W  vector writeback index
- I_WBCCEn  in  1  CC writeback this cycle
- O_DepStall  out  1  combinational; hazard present for the current instruction
- O_Issue  out  1  combinational; instruction issues this cycle
- O_Busy  out  1  registered; any counter non-zero
- O_Underflow  out  1  registered, sticky; writeback arrived for a counter already at 0

Behaviour:
- State: one CNT_W counter per scalar register, one per vector register, one for CC. All are cleared asynchronously when I_RESET_N=0. On reset O_Busy=0 and O_Underflow=0; combinational outputs follow from zeroed state (O_DepStall=0).
- RAW hazard for each used source (scalar, vector, CC-read): counter ≠ 0.
- Saturation hazard for each written destination (scalar, vector, CC-write): counter == MAX_INFLIGHT.
- O_DepStall = I_IssueValid & (any RAW hazard | any saturation hazard).
- O_Issue = I_IssueValid & ~O_DepStall & ~I_Hold.
- Hazards are evaluated on current counters only; there is no same-cycle writeback bypass. A writeback at edge N releases a dependent stall in the cycle after edge N.
- Counter update at the rising edge, per counter:
  - +1 if O_Issue and this entry is the written destination.
  - −1 if the matching writeback is enabled and the counter is > 0.
  - Both in the same cycle: net unchanged.
- Writeback to an entry whose counter is 0: counter stays 0 and O_Underflow sets; it stays set until reset.
- A scalar, vector and CC write from one instruction each increment their own counter in the same cycle.
- The same index used as source and destination is a hazard only if that counter is already non-zero.
- WAW is allowed up to MAX_INFLIGHT; in-order writeback is guaranteed by the pipeline.
- I_Hold=1 means no increments, but writebacks still decrement.
- O_Busy is registered from the next-state counters, so it is valid in the cycle after the edge.
- Reset asserted mid-operation clears all pending state immediately; in-flight writebacks arriving after reset set O_Underflow.

Test Plan:
- Reset: I_RESET_N=0 for 2 cycles, then 1. Expect O_Busy=0, O_Underflow=0; issue of src R1 → O_DepStall=0, O_Issue=1.
- RAW: issue dest R3 at cycle 0; cycle 1 src1=R3 → O_DepStall=1; I_WBRegEn with idx 3 at cycle 3 → stall held in cycle 3, O_Issue=1 in cycle 4; R3 counter back to 0, so O_Busy=0 once that writeback has retired.
- Simultaneous: R3 count=1; in the same cycle issue dest R3 and WB R3 → count stays 1; next-cycle src R3 → stall.
- Saturation: three issues with dest R5 and no writeback → fourth dest-R5 issue gives O_DepStall=1; one WB R5 → it issues the following cycle.
- Hold and CC: I_Hold=1 with a valid hazard-free instr → O_Issue=0, counters unchanged. CMP (CC write) then branch (CC read) → branch stalls until I_WBCCEn, then issues the next cycle.
- Vector/underflow/async reset: VDest V10 issued, VSrc2=V10 stalls. A WB to V20 with count 0 → O_Underflow=1 (sticky). Assert I_RESET_N low between edges → counters and flags clear immediately, V10 no longer stalls.
